// File: rtl/ex_div_pkg.sv
// ============================================================================
// Module : ex_div_pkg
// Brief  : Shared types and opcodes for the EX-stage iterative divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex_div_pkg;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_e;

    // ALU opcodes that the EX stage routes to this unit
    localparam logic [7:0] c_ALUOP_DIV  = 8'b00011010;
    localparam logic [7:0] c_ALUOP_DIVU = 8'b00011011;

endpackage : ex_div_pkg

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// Module : ex_div
// Brief  : Iterative radix-2 restoring divider (DIV/DIVU), start/ready handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    div_state_e           r_state;
    div_state_e           w_state_nxt;
    logic [WIDTH-1:0]     r_dvd;      // dividend bits shift out MSB-first, quotient bits shift in
    logic [WIDTH-1:0]     r_dsr;
    logic [WIDTH-1:0]     r_rem;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg1;
    logic                 r_neg2;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_accept;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH:0]       w_trial;
    logic                 w_qbit;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic                 w_last;

    assign w_accept = start_i & ~annul_i;
    assign w_neg1   = signed_i & opdata1_i[WIDTH-1];
    assign w_neg2   = signed_i & opdata2_i[WIDTH-1];
    assign w_abs1   = w_neg1 ? -opdata1_i : opdata1_i;
    assign w_abs2   = w_neg2 ? -opdata2_i : opdata2_i;

    // No borrow out of the WIDTH+1-bit trial means the divisor fits: keep it.
    assign w_trial   = {r_rem, r_dvd[WIDTH-1]} - {1'b0, r_dsr};
    assign w_qbit    = ~w_trial[WIDTH];
    assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // Remainder follows the dividend sign; MIN/-1 wraps back to MIN.
    assign w_quo_fix = (r_neg1 ^ r_neg2) ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg1 ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_FREE: begin
                if (w_accept) begin
                    w_state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: w_state_nxt = annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (annul_i) begin
                    w_state_nxt = DIV_FREE;
                end else if (w_last) begin
                    w_state_nxt = DIV_END;
                end
            end
            DIV_END:  w_state_nxt = start_i ? DIV_END : DIV_FREE;
            default:  w_state_nxt = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= DIV_FREE;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                DIV_FREE: begin
                    if (w_accept) begin
                        r_dvd  <= w_abs1;
                        r_dsr  <= w_abs2;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_neg1 <= w_neg1;
                        r_neg2 <= w_neg2;
                    end
                end
                DIV_BY_ZERO: r_result <= '0;
                DIV_ON: begin
                    if (!annul_i) begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_quo_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                        end
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        r_result <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state == DIV_BY_ZERO) || (r_state == DIV_ON);
    assign ready_o  = (r_state == DIV_END);
    assign result_o = r_result;

endmodule : ex_div

`default_nettype wire

// File: tb/tb_ex_div.sv
// ============================================================================
// Module : tb_ex_div
// Brief  : Directed self-checking bench for ex_div at WIDTH=32 and WIDTH=8.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_div;

    logic        clk;
    logic        rst;
    logic        sgn, start, annul;
    logic [31:0] op1, op2;
    logic        busy, ready;
    logic [63:0] result;

    logic        sgn8, start8;
    logic [7:0]  op1_8, op2_8;
    logic        busy8, ready8;
    logic [15:0] result8;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        s;
        logic [31:0] a, b, q, r;
    } vec32_t;

    typedef struct {
        logic       s;
        logic [7:0] a, b, q, r;
    } vec8_t;

    ex_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .signed_i(sgn), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .busy_o(busy), .ready_o(ready), .result_o(result)
    );

    ex_div #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .signed_i(sgn8), .opdata1_i(op1_8), .opdata2_i(op2_8),
        .start_i(start8), .annul_i(1'b0), .busy_o(busy8), .ready_o(ready8), .result_o(result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operation (operands scrambled once accepted) and waits for ready.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input bit keep, output logic [31:0] q, output logic [31:0] r,
                           output int cyc, output int bcnt);
        @(negedge clk);
        sgn = s; op1 = a; op2 = b; start = 1'b1;
        cyc = 0; bcnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            op1 = ~a; op2 = b ^ 32'h5; sgn = ~s;
            if (busy) bcnt++;
        end while (!ready && cyc < 200);
        q = result[31:0];
        r = result[63:32];
        if (!keep) start = 1'b0;
    endtask

    task automatic run_div8(input logic s, input logic [7:0] a, input logic [7:0] b,
                            output logic [7:0] q, output logic [7:0] r, output int cyc);
        @(negedge clk);
        sgn8 = s; op1_8 = a; op2_8 = b; start8 = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready8 && cyc < 100);
        q = result8[7:0];
        r = result8[15:8];
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sgn = 0; start = 0; annul = 0; op1 = 0; op2 = 0;
        sgn8 = 0; start8 = 0; op1_8 = 0; op2_8 = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, ready, result} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b ready=%b result=%h want all 0", busy, ready, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        logic [31:0] q, r;
        int cyc, bcnt;
        run_div(1'b0, 32'd100, 32'd7, 1'b0, q, r, cyc, bcnt);
        n_cmp++;
        if (q !== 32'd14 || r !== 32'd2) begin
            n_err++; $display("FAIL divu_100_7: q=%0d r=%0d want q=14 r=2", q, r);
        end
        n_cmp++;
        if (cyc !== 33) begin
            n_err++; $display("FAIL divu_latency: got %0d want 33", cyc);
        end
        n_cmp++;
        if (bcnt !== 32) begin
            n_err++; $display("FAIL divu_busy_cycles: got %0d want 32", bcnt);
        end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL end_to_free: ready=%b busy=%b result=%h want 0/0/0", ready, busy, result);
        end
    endtask

    task automatic test_by_zero();
        logic [31:0] q, r;
        int cyc, bcnt;
        run_div(1'b0, 32'd12345, 32'd0, 1'b0, q, r, cyc, bcnt);
        n_cmp++;
        if (q !== 32'd0 || r !== 32'd0) begin
            n_err++; $display("FAIL by_zero_result: q=%h r=%h want 0/0", q, r);
        end
        n_cmp++;
        if (cyc !== 2 || bcnt !== 1) begin
            n_err++; $display("FAIL by_zero_timing: cyc=%0d busy=%0d want 2/1", cyc, bcnt);
        end
    endtask

    task automatic test_table32();
        logic [31:0] q, r;
        int cyc, bcnt;
        vec32_t tbl[8];
        tbl[0] = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        tbl[1] = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        tbl[2] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
        tbl[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        tbl[4] = '{1'b0, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 32'd1};
        tbl[5] = '{1'b0, 32'd5,        32'd10,       32'd0,        32'd5};
        tbl[6] = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1};
        tbl[7] = '{1'b0, 32'd1000000,  32'd1000,     32'd1000,     32'd0};
        foreach (tbl[i]) begin
            run_div(tbl[i].s, tbl[i].a, tbl[i].b, 1'b0, q, r, cyc, bcnt);
            n_cmp++;
            if (q !== tbl[i].q || r !== tbl[i].r || cyc !== 33) begin
                n_err++;
                $display("FAIL vec32[%0d]: q=%h r=%h cyc=%0d want q=%h r=%h cyc=33",
                         i, q, r, cyc, tbl[i].q, tbl[i].r);
            end
        end
    endtask

    task automatic test_annul();
        logic [31:0] q, r;
        int cyc, bcnt;
        bit seen_ready;
        @(negedge clk);
        sgn = 0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_err++; $display("FAIL annul_to_free: busy=%b ready=%b want 0/0", busy, ready);
        end
        seen_ready = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen_ready = 1;
        end
        n_cmp++;
        if (seen_ready) begin
            n_err++; $display("FAIL annul_no_ready: ready rose after annul, want never");
        end
        run_div(1'b0, 32'd50, 32'd5, 1'b0, q, r, cyc, bcnt);
        n_cmp++;
        if (q !== 32'd10 || r !== 32'd0 || cyc !== 33) begin
            n_err++; $display("FAIL after_annul_50_5: q=%0d r=%0d cyc=%0d want 10/0/33", q, r, cyc);
        end
        // annul while idle must block acceptance
        @(negedge clk);
        start = 1'b1; annul = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_err++; $display("FAIL annul_blocks_free: busy=%b ready=%b want 0/0", busy, ready);
        end
        start = 1'b0; annul = 1'b0;
    endtask

    task automatic test_hold_end();
        logic [31:0] q, r;
        int cyc, bcnt;
        bit bad;
        run_div(1'b0, 32'd100, 32'd7, 1'b1, q, r, cyc, bcnt);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            annul = 1'b1;
            if (ready !== 1'b1 || busy !== 1'b0 || result !== {32'd2, 32'd14}) bad = 1;
        end
        annul = 1'b0;
        n_cmp++;
        if (bad) begin
            n_err++; $display("FAIL hold_end: ready=%b busy=%b result=%h want 1/0/%h",
                              ready, busy, result, {32'd2, 32'd14});
        end
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL hold_release: ready=%b result=%h want 0/0", ready, result);
        end
    endtask

    task automatic test_reset_mid_on();
        @(negedge clk);
        sgn = 1; op1 = 32'hFFFFFF00; op2 = 32'd3; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
            n_err++; $display("FAIL reset_mid_on: busy=%b ready=%b result=%h want 0/0/0", busy, ready, result);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_width8();
        logic [7:0] q, r;
        int cyc;
        vec8_t tbl[4];
        tbl[0] = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00};
        tbl[1] = '{1'b0, 8'd200, 8'd7, 8'd28, 8'd4};
        tbl[2] = '{1'b1, 8'h9C, 8'd7, 8'hF2, 8'hFE};
        tbl[3] = '{1'b0, 8'd255, 8'd16, 8'd15, 8'd15};
        foreach (tbl[i]) begin
            run_div8(tbl[i].s, tbl[i].a, tbl[i].b, q, r, cyc);
            n_cmp++;
            if (q !== tbl[i].q || r !== tbl[i].r || cyc !== 9) begin
                n_err++;
                $display("FAIL vec8[%0d]: q=%h r=%h cyc=%0d want q=%h r=%h cyc=9",
                         i, q, r, cyc, tbl[i].q, tbl[i].r);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_divu_basic();
        test_by_zero();
        test_table32();
        test_annul();
        test_hold_end();
        test_reset_mid_on();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ex_div

`default_nettype wire
